// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one-cycle multiplier, WIDTH-step restoring divider.
// Optional macro DIV_ZERO_FAST_EN short-circuits divide-by-zero to a single DIV cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic             unsigned_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quot, rem, dvsr;
  logic [WIDTH-1:0] res_hi, res_lo, hold_hi, hold_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_shift, diff;
  logic [WIDTH-1:0]   quot_nxt, rem_nxt, fix_hi, fix_lo;
  logic               neg_q, neg_r, fast_zero;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (b_q == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Sign- or zero-extend to 2*WIDTH so one unsigned multiply covers MULT and MULTU.
  assign prod = {{WIDTH{~unsigned_q & a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{~unsigned_q & b_q[WIDTH-1]}}, b_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rem_shift = {rem, quot[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvsr};
    rem_nxt   = rem_shift[WIDTH-1:0];
    quot_nxt  = {quot[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_nxt  = diff[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end
  end

  // Quotient sign follows operand sign mismatch, remainder follows the dividend.
  assign neg_q  = ~unsigned_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_r  = ~unsigned_q & a_q[WIDTH-1];
  assign fix_lo = neg_q ? -quot_nxt : quot_nxt;
  assign fix_hi = neg_r ? -rem_nxt : rem_nxt;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= IDLE;
      unsigned_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      count      <= '0;
      quot       <= '0;
      rem        <= '0;
      dvsr       <= '0;
      res_hi     <= '0;
      res_lo     <= '0;
      hold_hi    <= '0;
      hold_lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            unsigned_q <= op_i[0];
            a_q        <= src1_i;
            b_q        <= src2_i;
            quot       <= mag(src1_i, ~op_i[0]);
            dvsr       <= mag(src2_i, ~op_i[0]);
            rem        <= '0;
            count      <= '0;
            state      <= op_i[1] ? DIV : MUL;
          end
        end
        MUL: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            {res_hi, res_lo} <= prod;
            state            <= DONE;
          end
        end
        DIV: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (fast_zero) begin
            res_hi <= a_q;
            res_lo <= '1;
            state  <= DONE;
          end else begin
            quot  <= quot_nxt;
            rem   <= rem_nxt;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              res_hi <= fix_hi;
              res_lo <= fix_lo;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flush_i) begin
            hold_hi <= res_hi;
            hold_lo <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush in DONE must retract both the strobe and the new result in the same cycle.
  assign we_o    = (state == DONE) & ~flush_i;
  assign hi_o    = we_o ? res_hi : hold_hi;
  assign lo_o    = we_o ? res_lo : hold_lo;
  assign busy_o  = (state != IDLE);
  assign stall_o = ~cpu_rst & (((state == IDLE) & start_i & ~flush_i) |
                               (state == MUL) | (state == DIV));

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops vs. an arithmetic model.
// Define DIV_ZERO_FAST_EN consistently for bench and RTL.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src1 = '0, src2 = '0;
  wire          stall, busy, we;
  wire  [W-1:0] hi, lo;

  int checks = 0, failures = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  muldiv_seq #(.WIDTH(W)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .start_i(start), .op_i(op),
    .src1_i(src1), .src2_i(src2), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .we_o(we), .hi_o(hi), .lo_o(lo)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] absv(input logic [W-1:0] x, input bit s);
    return (s && x[W-1]) ? (~x + 1'b1) : x;
  endfunction

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                output logic [W-1:0] eh, el, output int lat);
    logic [63:0]  p;
    logic [W-1:0] qm, rm;
    longint       sa, sb;
    bit           s = ~o[0];
    if (!o[1]) begin
      lat = 2;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      eh = p[63:32];
      el = p[31:0];
      return;
    end
    lat = W + 1;
    if (b == '0) begin
`ifdef DIV_ZERO_FAST_EN
      eh  = a;
      el  = '1;
      lat = 2;
      return;
`else
      qm = '1;
      rm = absv(a, s);
`endif
    end else begin
      qm = absv(a, s) / absv(b, s);
      rm = absv(a, s) % absv(b, s);
    end
    el = (s && (a[W-1] ^ b[W-1])) ? -qm : qm;
    eh = (s && a[W-1]) ? -rm : rm;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, b,
                        input string tag, input bit hold = 1'b0);
    logic [W-1:0] eh, el;
    int lat, edges = 0, stalls = 0;
    bit seen = 1'b0;
    model(o, a, b, eh, el, lat);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    #1 if (stall) stalls++;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (hold) begin
        op = ~o; src1 = $urandom; src2 = $urandom;
      end else begin
        start = 1'b0;
      end
      if (we) seen = 1'b1;
      else if (stall) stalls++;
    end
    start = 1'b0;
    check({tag, "_we_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(lat));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
    @(negedge clk);
    check({tag, "_we_once"}, 64'({we, busy}), 64'd0);
    check({tag, "_hold_hi"}, 64'(hi), 64'(eh));
    check({tag, "_hold_lo"}, 64'(lo), 64'(el));
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    #5;
    check("reset_ctrl", 64'({stall, busy, we}), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    check("mult_neg_const_lo", 64'(lo), 64'hFFFF_FFFA);
    check("mult_neg_const_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu_const", 64'({hi, lo}), 64'h0000_0001_FFFF_FFFE);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b1);
    check("div_neg_const", 64'({hi, lo}), 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd0, "divu_zero");
    check("divu_zero_const", 64'({hi, lo}), 64'h0000_0064_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", 64'({hi, lo}), 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_neg_zero");

    // Flush mid-divide, then relaunch immediately
    @(negedge clk);
    op = 2'b11; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_div_we", 64'(we), 64'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_div_idle", 64'({busy, we}), 64'd0);
    check("flush_div_hold", 64'({hi, lo}), 64'({last_hi, last_lo}));
    run_op(2'b11, 32'd100, 32'd7, "divu_after_flush");
    check("divu_after_flush_const", 64'({hi, lo}), 64'h0000_0002_0000_000E);

    // Flush while in DONE retracts the write and the result
    @(negedge clk);
    op = 2'b00; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_done_we", 64'({we, busy}), 64'd1);
    check("flush_done_out", 64'({hi, lo}), 64'({last_hi, last_lo}));
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_idle", 64'(busy), 64'd0);
    check("flush_done_hold", 64'({hi, lo}), 64'({last_hi, last_lo}));

    // start and flush together in IDLE do not launch
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00;
    #1 check("start_flush_stall", 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", 64'(busy), 64'd0);

    // Asynchronous reset between edges during a divide
    @(negedge clk);
    op = 2'b10; src1 = 32'hFFFF_FFF9; src2 = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #5 rst = 1'b1;
    #1 check("async_rst_ctrl", 64'({stall, busy, we}), 64'd0);
    check("async_rst_out", 64'({hi, lo}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b11, 32'd1000, 32'd33, "after_reset");

    // Random operations against the model
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 1) != 0) ra = ~ra;
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO word width.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 Port: cpu_clk_50M  in  1  sole clock, rising edge.
REQ-004 Port: cpu_rst  in  1  asynchronous active-high reset.
REQ-005 Port: start_i  in  1  launch request; sampled only in IDLE.
REQ-006 Port: op_i  in  2  opcode: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: src1_i  in  WIDTH  multiplicand or dividend.
REQ-008 Port: src2_i  in  WIDTH  multiplier or divisor.
REQ-009 Port: flush_i  in  1  abort the operation in progress.
REQ-010 Port: stall_o  out  1  pipeline hold request.
REQ-011 Port: busy_o  out  1  high whenever state is not IDLE.
REQ-012 Port: we_o  out  1  one-cycle HI/LO register-file write strobe.
REQ-013 Port: hi_o  out  WIDTH  high product word or remainder.
REQ-014 Port: lo_o  out  WIDTH  low product word or quotient.

Function
REQ-015 The FSM SHALL have four states: IDLE, MUL, DIV, DONE.
REQ-016 IDLE with start_i=1 and flush_i=0 SHALL latch op_i, src1_i and src2_i, then go to MUL (op_i[1]=0) or DIV (op_i[1]=1).
REQ-017 MUL SHALL form the full 2*WIDTH product in one cycle (signed for MULT, unsigned for MULTU), register it and go to DONE.
REQ-018 DIV SHALL run a restoring divider on operand magnitudes for exactly WIDTH iterations, counted by a 0..WIDTH-1 counter, then go to DONE.
REQ-019 Signed DIV: quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-020 The 0x80000000 / -1 case SHALL return lo=0x80000000, hi=0.
REQ-021 DONE SHALL assert we_o for exactly one cycle with the final hi_o/lo_o, then go to IDLE.
REQ-022 Latency from the start-sampling edge to we_o: 2 edges for MUL, WIDTH+1 edges for DIV.
REQ-023 stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV; stall_o SHALL be 0 in DONE so the issuing instruction retires with the result.
REQ-024 hi_o and lo_o SHALL hold their last values outside DONE.
REQ-025 flush_i=1 in MUL, DIV or DONE SHALL force IDLE on the next edge, suppress we_o in that cycle, and leave hi_o/lo_o unchanged.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 start_i and flush_i both high in IDLE SHALL not launch an operation.

Reset
REQ-028 cpu_rst=1 SHALL asynchronously force IDLE and clear the counter and operand registers.
REQ-029 Reset SHALL drive stall_o=0, busy_o=0, we_o=0, hi_o=0 and lo_o=0.
REQ-030 Reset asserted mid-operation SHALL discard the operation without asserting we_o.

Configuration
REQ-031 DIV_ZERO_FAST_EN defined: DIV/DIVU with src2_i=0 SHALL go directly to DONE after one cycle, giving hi_o=src1_i and lo_o=all ones.
REQ-032 DIV_ZERO_FAST_EN undefined: divide-by-zero SHALL run the full WIDTH iterations and output whatever the divider produces, including sign fix-up.

Verification
REQ-033 MULT src1=0xFFFFFFFE (-2), src2=3 -> we_o 2 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 MULTU src1=0xFFFFFFFF, src2=2 -> hi=0x00000001, lo=0xFFFFFFFE; stall_o high for exactly 2 cycles.
REQ-035 DIV src1=-7 (0xFFFFFFF9), src2=2 -> we_o after 33 edges; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU src1=100, src2=0: with macro -> we_o after 2 edges, hi=100, lo=0xFFFFFFFF; without macro -> we_o after 33 edges, hi=100, lo=0xFFFFFFFF.
REQ-037 DIVU 100/7 with flush_i pulsed on iteration 10 -> IDLE next edge, no we_o, hi/lo keep prior values; an immediate new DIVU 100/7 -> lo=14, hi=2.
REQ-038 cpu_rst asserted between clock edges during DIV iteration 5 -> all outputs 0 immediately; start_i after release is accepted normally.
